// File: rtl/math_pipe_pkg.sv
// Shared types and helpers for the pipelined subtractor.
package math_pipe_pkg;

  localparam int unsigned DEFAULT_STAGES = 4;

  // Per-stage control record; the chunk difference travels beside it.
  typedef struct packed {
    logic valid;
    logic borrow;
    logic zero;
  } stage_rec_t;

  function automatic int unsigned chunk_count(input int unsigned n, input int unsigned stages);
    return n / stages;
  endfunction

endpackage

// File: rtl/math_subtractor_full_nbit.sv
// Combinational W-bit subtractor: diff_c = a - b - b_in, borrow_c = unsigned borrow out.
module math_subtractor_full_nbit #(
  parameter int unsigned W = 8
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         b_in,
  output logic [W-1:0] diff_c,
  output logic         borrow_c
);

  localparam int unsigned WE = W + 1;

  logic [W:0] full;

  // The extra top bit of the widened difference is the borrow.
  assign full     = {1'b0, a} - {1'b0, b} - WE'(b_in);
  assign diff_c   = full[W-1:0];
  assign borrow_c = full[W];

endmodule

// File: rtl/math_subtractor_pipe_stage.sv
// One pipeline stage: resolves one operand chunk and registers difference, borrow, valid and zero flag.
module math_subtractor_pipe_stage
  import math_pipe_pkg::*;
#(
  parameter int unsigned CHUNK = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             adv,
  input  logic             valid,
  input  logic             borrow,
  input  logic             zero,
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  output stage_rec_t       rec,
  output logic [CHUNK-1:0] diff
);

  logic [CHUNK-1:0] diff_c;
  logic             borrow_c;

  math_subtractor_full_nbit #(.W(CHUNK)) u_sub (
    .a        (a),
    .b        (b),
    .b_in     (borrow),
    .diff_c   (diff_c),
    .borrow_c (borrow_c)
  );

  // zero accumulates "all chunks resolved so far are zero"
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rec  <= '0;
      diff <= '0;
    end else if (adv) begin
      rec.valid  <= valid;
      rec.borrow <= borrow_c;
      rec.zero   <= zero & ~|diff_c;
      diff       <= diff_c;
    end
  end

endmodule

// File: rtl/math_subtractor_pipelined_nbit.sv
// Pipelined N-bit subtractor D = A - B - Bin, one CHUNK per stage, valid/ready with full backpressure.
// Optional MATH_SUBTRACTOR_SATURATE_EN: floor o_d at 0 when the final borrow is set.
module math_subtractor_pipelined_nbit
  import math_pipe_pkg::*;
#(
  parameter int unsigned N      = 32,
  parameter int unsigned STAGES = DEFAULT_STAGES
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_valid,
  output logic         o_ready,
  input  logic [N-1:0] i_a,
  input  logic [N-1:0] i_b,
  input  logic         i_b_in,
  output logic         o_valid,
  input  logic         i_ready,
  output logic [N-1:0] o_d,
  output logic         o_b,
  output logic         o_zero
);

  localparam int unsigned CHUNK = chunk_count(N, STAGES);

  if (N % STAGES != 0) begin : g_bad_cfg
    $error("math_subtractor_pipelined_nbit: N must be a multiple of STAGES");
  end

  logic adv;

  // Operand view entering each stage, skewed operands, deskewed differences.
  logic [N-1:0]     a_op  [STAGES];
  logic [N-1:0]     b_op  [STAGES];
  logic [N-1:0]     a_sk  [STAGES];
  logic [N-1:0]     b_sk  [STAGES];
  logic [N-1:0]     d_ds  [STAGES];
  logic [N-1:0]     d_acc [STAGES];
  logic [CHUNK-1:0] dq    [STAGES];
  stage_rec_t       rec   [STAGES];

  assign adv     = !o_valid || i_ready;
  assign o_ready = i_rst_n && adv;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic [CHUNK-1:0] a_c;
    logic [CHUNK-1:0] b_c;
    logic             v_in;
    logic             bo_in;
    logic             z_in;

    if (k == 0) begin : g_src
      assign a_op[k] = i_a;
      assign b_op[k] = i_b;
      assign v_in    = i_valid;
      assign bo_in   = i_b_in;
      assign z_in    = 1'b1;
    end else begin : g_src
      assign a_op[k] = a_sk[k-1];
      assign b_op[k] = b_sk[k-1];
      assign v_in    = rec[k-1].valid;
      assign bo_in   = rec[k-1].borrow;
      assign z_in    = rec[k-1].zero;
    end

    assign a_c = a_op[k][k*CHUNK +: CHUNK];
    assign b_c = b_op[k][k*CHUNK +: CHUNK];

    math_subtractor_pipe_stage #(.CHUNK(CHUNK)) u_stage (
      .clk    (i_clk),
      .rst_n  (i_rst_n),
      .adv    (adv),
      .valid  (v_in),
      .borrow (bo_in),
      .zero   (z_in),
      .a      (a_c),
      .b      (b_c),
      .rec    (rec[k]),
      .diff   (dq[k])
    );

    // Upper chunks not yet consumed ride along to later stages.
    if (k < STAGES - 1) begin : g_skew
      localparam int unsigned LO = (k + 1) * CHUNK;
      always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
          a_sk[k] <= '0;
          b_sk[k] <= '0;
        end else if (adv) begin
          a_sk[k][N-1:LO] <= a_op[k][N-1:LO];
          b_sk[k][N-1:LO] <= b_op[k][N-1:LO];
        end
      end
    end

    // Lower difference chunks already resolved are delayed to line up with chunk k.
    if (k > 0) begin : g_deskew
      always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
          d_ds[k] <= '0;
        end else if (adv) begin
          d_ds[k] <= d_acc[k-1];
        end
      end
      assign d_acc[k] = d_ds[k] | (N'(dq[k]) << (k * CHUNK));
    end else begin : g_deskew
      assign d_acc[k] = N'(dq[k]);
    end
  end

  assign o_valid = rec[STAGES-1].valid;
  assign o_b     = rec[STAGES-1].borrow;
  assign o_zero  = rec[STAGES-1].zero;

`ifdef MATH_SUBTRACTOR_SATURATE_EN
  assign o_d = o_b ? '0 : d_acc[STAGES-1];
`else
  assign o_d = d_acc[STAGES-1];
`endif

endmodule

// File: tb/tb_math_subtractor_pipelined_nbit.sv
// Self-checking bench: scoreboard model of the pipelined subtractor plus directed literal checks.
module tb_math_subtractor_pipelined_nbit;

  localparam int unsigned N      = 16;
  localparam int unsigned STAGES = 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         valid;
  logic         ready;
  logic         b_in;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic         o_ready;
  logic         o_valid;
  logic         o_b;
  logic         o_zero;
  logic [N-1:0] o_d;

  int tests = 0;
  int fails = 0;
  bit armed = 1'b0;

  typedef struct {
    logic [N-1:0] d;
    logic         b;
    logic         z;
    int           age;
  } exp_t;

  exp_t q[$];
  bit   m_ev;
  bit   m_adv;

  math_subtractor_pipelined_nbit #(.N(N), .STAGES(STAGES)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .i_valid (valid),
    .o_ready (o_ready),
    .i_a     (a),
    .i_b     (b),
    .i_b_in  (b_in),
    .o_valid (o_valid),
    .i_ready (ready),
    .o_d     (o_d),
    .o_b     (o_b),
    .o_zero  (o_zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected result from plain integer arithmetic.
  function automatic exp_t calc(input logic [N-1:0] x, input logic [N-1:0] y, input logic bi);
    exp_t e;
    int   diff;
    logic [N-1:0] w;
    diff  = int'(x) - int'(y) - int'(bi);
    w     = N'(diff);
    e.b   = (diff < 0);
    e.z   = (w == '0);
`ifdef MATH_SUBTRACTOR_SATURATE_EN
    e.d   = e.b ? '0 : w;
`else
    e.d   = w;
`endif
    e.age = 1;
    return e;
  endfunction

  // Model: a beat becomes visible after STAGES advancing edges and leaves on a ready edge.
  always @(negedge clk) begin
    if (armed) begin
      m_ev = (q.size() > 0) && (q[0].age == int'(STAGES));
      chk("o_valid", 32'(o_valid), 32'(m_ev));
      chk("o_ready", 32'(o_ready), 32'(rst_n && (!m_ev || ready)));
      if (m_ev) begin
        chk("o_d", 32'(o_d), 32'(q[0].d));
        chk("o_b", 32'(o_b), 32'(q[0].b));
        chk("o_zero", 32'(o_zero), 32'(q[0].z));
      end
      if (!rst_n) begin
        q.delete();
      end else begin
        m_adv = !m_ev || ready;
        if (m_adv) begin
          if (m_ev) void'(q.pop_front());
          foreach (q[i]) q[i].age = q[i].age + 1;
          if (valid) q.push_back(calc(a, b, b_in));
        end
      end
    end
  end

  // Send one beat into an empty pipeline and pin its latency; ends on the negedge it is visible.
  task automatic send1(input logic [N-1:0] x, input logic [N-1:0] y, input logic bi);
    a = x; b = y; b_in = bi; valid = 1'b1;
    @(posedge clk); #1;
    valid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("lat_early", 32'(o_valid), 32'(0));
    @(posedge clk);
    @(negedge clk);
    chk("lat_valid", 32'(o_valid), 32'(1));
  endtask

  task automatic rand_beat();
    a = N'($urandom); b = N'($urandom); b_in = 1'($urandom_range(1)); valid = 1'b1;
  endtask

  exp_t         e;
  logic [N-1:0] held;

  initial begin
    rst_n = 1'b0; valid = 1'b0; ready = 1'b1; a = '0; b = '0; b_in = 1'b0;
    @(posedge clk);
    armed = 1'b1;
    @(negedge clk);
    chk("rst_valid", 32'(o_valid), 32'(0));
    chk("rst_d", 32'(o_d), 32'(0));
    chk("rst_b", 32'(o_b), 32'(0));
    chk("rst_zero", 32'(o_zero), 32'(0));
    @(posedge clk); #1;
    rst_n = 1'b1;

    send1(16'h1234, 16'h0235, 1'b0);
    chk("t1_d", 32'(o_d), 32'h0FFF);
    chk("t1_b", 32'(o_b), 32'(0));
    chk("t1_zero", 32'(o_zero), 32'(0));
    @(posedge clk); #1;

    send1(16'h0000, 16'h0001, 1'b0);
`ifdef MATH_SUBTRACTOR_SATURATE_EN
    chk("t2_d", 32'(o_d), 32'h0000);
`else
    chk("t2_d", 32'(o_d), 32'hFFFF);
`endif
    chk("t2_b", 32'(o_b), 32'(1));
    chk("t2_zero", 32'(o_zero), 32'(0));
    @(posedge clk); #1;

    send1(16'h8000, 16'h7FFF, 1'b1);
    chk("t3_d", 32'(o_d), 32'h0000);
    chk("t3_b", 32'(o_b), 32'(0));
    chk("t3_zero", 32'(o_zero), 32'(1));
    @(posedge clk); #1;

    // Eight back-to-back beats must emerge on eight consecutive cycles.
    fork
      begin
        for (int i = 0; i < 8; i++) begin
          a = N'(i * 16'h1111); b = 16'h0101; b_in = 1'b0; valid = 1'b1;
          @(posedge clk); #1;
        end
        valid = 1'b0;
      end
      begin
        @(posedge clk);
        repeat (3) @(posedge clk);
        for (int j = 0; j < 8; j++) begin
          @(negedge clk);
          e = calc(N'(j * 16'h1111), 16'h0101, 1'b0);
          chk("b2b_valid", 32'(o_valid), 32'(1));
          chk("b2b_ready", 32'(o_ready), 32'(1));
          chk("b2b_d", 32'(o_d), 32'(e.d));
          @(posedge clk);
        end
      end
    join
    #1;

    // Fill the pipeline, then stall the output for five cycles.
    for (int i = 0; i < 4; i++) begin
      rand_beat();
      @(posedge clk); #1;
    end
    ready = 1'b0;
    rand_beat();
    held = '0;
    for (int j = 0; j < 5; j++) begin
      @(negedge clk);
      if (j == 0) held = o_d;
      chk("stall_valid", 32'(o_valid), 32'(1));
      chk("stall_ready", 32'(o_ready), 32'(0));
      chk("stall_hold", 32'(o_d), 32'(held));
      @(posedge clk); #1;
    end
    ready = 1'b1;
    @(posedge clk); #1;
    valid = 1'b0;
    repeat (8) @(posedge clk);
    #1;

    // Reset with three beats in flight; a beat offered during reset is ignored.
    for (int i = 0; i < 3; i++) begin
      rand_beat();
      @(posedge clk); #1;
    end
    rst_n = 1'b0;
    rand_beat();
    @(posedge clk); #1;
    rst_n = 1'b1;
    valid = 1'b0;
    @(negedge clk);
    chk("rst_flush_valid", 32'(o_valid), 32'(0));
    repeat (8) @(posedge clk);
    #1;
    e = calc(16'hBEEF, 16'h1234, 1'b1);
    send1(16'hBEEF, 16'h1234, 1'b1);
    chk("fresh_d", 32'(o_d), 32'(e.d));
    chk("fresh_b", 32'(o_b), 32'(e.b));
    @(posedge clk); #1;

    // Random traffic with random backpressure.
    for (int c = 0; c < 400; c++) begin
      valid = ($urandom_range(3) != 0);
      ready = ($urandom_range(2) != 0);
      a = N'($urandom);
      b = N'($urandom);
      b_in = 1'($urandom_range(1));
      if ($urandom_range(7) == 0) b = a;
      if ($urandom_range(15) == 0) a = '0;
      @(posedge clk); #1;
    end
    valid = 1'b0;
    ready = 1'b1;
    repeat (10) @(posedge clk);
    #1;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
